// File: rtl/emergency_system_pkg.sv
// Shared types and defaults for the latching emergency alarm controller.
package emergency_system_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  localparam int SYNC_STAGES_DEF      = 2;
  localparam int BUZZ_HALF_CYCLES_DEF = 4;
  localparam int CNT_W_DEF            = 16;

endpackage

// File: rtl/emergency_system_if.sv
// Board-side signals of the alarm: two raw trigger inputs and two actuator pins.
interface emergency_system_if;

  logic btn_activate;
  logic smoke_detected;
  logic buzzer;
  logic led_alert;

  modport master (
    output btn_activate,
    output smoke_detected,
    input  buzzer,
    input  led_alert
  );

  modport slave (
    input  btn_activate,
    input  smoke_detected,
    output buzzer,
    output led_alert
  );

endinterface

// File: rtl/emergency_system_sync_2ff.sv
// Single-bit multi-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/emergency_system.sv
// Latching emergency alarm: button edge or smoke level latches ALARM until reset;
// in ALARM the LED is steady and the buzzer is a square wave starting high.
//
// state | meaning
// IDLE  | no alarm, outputs low, watching for a trigger
// ALARM | latched alarm, LED on, buzzer toggling every BUZZ_HALF_CYCLES
module emergency_system
  import emergency_system_pkg::*;
#(
  parameter int SYNC_STAGES      = SYNC_STAGES_DEF,
  parameter int BUZZ_HALF_CYCLES = BUZZ_HALF_CYCLES_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  emergency_system_if.slave io
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_HALF_CYCLES - 1);

  logic             btn_sync;
  logic             smoke_sync;
  logic             btn_prev;
  logic             btn_rise;
  logic             trigger;
  state_t           state;
  logic [CNT_W-1:0] tone_cnt;
  logic             tone;
  logic             led_q;
  logic             buzzer_q;

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk   (clk),
    .reset (reset),
    .d     (io.btn_activate),
    .q     (btn_sync)
  );

  sync_2ff #(.STAGES(SYNC_STAGES)) u_sync_smoke (
    .clk   (clk),
    .reset (reset),
    .d     (io.smoke_detected),
    .q     (smoke_sync)
  );

  assign btn_rise = btn_sync & ~btn_prev;
  assign trigger  = btn_rise | smoke_sync;

  // Outputs are registered alongside the state so they track it edge for edge
  // with no path from the raw inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_prev <= 1'b0;
      state    <= IDLE;
      tone_cnt <= '0;
      tone     <= 1'b1;
      led_q    <= 1'b0;
      buzzer_q <= 1'b0;
    end else begin
      btn_prev <= btn_sync;
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= ALARM;
            tone_cnt <= '0;
            tone     <= 1'b1;
            led_q    <= 1'b1;
            buzzer_q <= 1'b1;
          end else begin
            led_q    <= 1'b0;
            buzzer_q <= 1'b0;
          end
        end
        ALARM: begin
          led_q <= 1'b1;
          if (tone_cnt == CNT_LAST) begin
            tone_cnt <= '0;
            tone     <= ~tone;
            buzzer_q <= ~tone;
          end else begin
            tone_cnt <= tone_cnt + CNT_W'(1);
            buzzer_q <= tone;
          end
        end
        default: begin
          state    <= IDLE;
          led_q    <= 1'b0;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign io.led_alert = led_q;
  assign io.buzzer    = buzzer_q;

endmodule

// File: tb/tb_emergency_system.sv
// Scoreboard bench for emergency_system: a cycle model of the trigger timing and
// tone pattern pushes expected pins per cycle; the post-edge sample pops and compares.
module tb_emergency_system;
  import emergency_system_pkg::*;

  localparam int H     = 4;
  localparam int NCYC  = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  emergency_system_if io ();

  emergency_system #(
    .SYNC_STAGES      (2),
    .BUZZ_HALF_CYCLES (H),
    .CNT_W            (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic  led;
    logic  buz;
    string tag;
  } exp_t;

  exp_t sb[$];

  int   checks = 0;
  int   errors = 0;
  int   t      = 0;
  int   rst_edge = 0;
  bit   m_alarm = 1'b0;
  int   m_n     = 0;
  logic hb [0:NCYC-1];
  logic hs [0:NCYC-1];

  task automatic check_val(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b want %b", tag, t, obs, exp);
    end
  endtask

  // Sample j counts only if it was taken after the last reset edge; earlier
  // samples were wiped out of the synchronizers.
  function automatic bit seen(input int j, input bit smoke);
    if (j <= rst_edge || j < 0) return 1'b0;
    return smoke ? hs[j] : hb[j];
  endfunction

  task automatic step(input logic r, input logic b, input logic s, input string tag);
    exp_t e;
    bit   trig;
    @(negedge clk);
    reset             = r;
    io.btn_activate   = b;
    io.smoke_detected = s;
    hb[t] = b;
    hs[t] = s;
    if (!r) begin
      m_alarm  = 1'b0;
      rst_edge = t;
    end else if (!m_alarm) begin
      trig = seen(t - 2, 1'b1) || (seen(t - 2, 1'b0) && !seen(t - 3, 1'b0));
      if (trig) begin
        m_alarm = 1'b1;
        m_n     = 0;
      end
    end else begin
      m_n++;
    end
    e.led = m_alarm;
    e.buz = m_alarm && (((m_n / H) % 2) == 0);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s cycle %0d: scoreboard empty", tag, t);
    end else begin
      e = sb.pop_front();
      check_val({e.tag, "_led"}, io.led_alert, e.led);
      check_val({e.tag, "_buz"}, io.buzzer, e.buz);
    end
    t++;
    if (t >= NCYC) begin
      $display("FAIL cycle_budget cycle %0d: got overrun want < %0d", t, NCYC);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic run(input int n, input logic r, input logic b, input logic s, input string tag);
    for (int i = 0; i < n; i++) step(r, b, s, tag);
  endtask

  int rise_cyc;

  initial begin
    io.btn_activate   = 1'b0;
    io.smoke_detected = 1'b0;

    run(2, 1'b0, 1'b0, 1'b0, "reset");
    run(5, 1'b1, 1'b0, 1'b0, "idle");

    // Button pulse, then stray triggers while latched must not disturb the tone.
    rise_cyc = t;
    run(2,  1'b1, 1'b1, 1'b0, "btn");
    run(10, 1'b1, 1'b0, 1'b0, "btn_hold");
    run(1,  1'b1, 1'b0, 1'b1, "alarm_smoke");
    run(1,  1'b1, 1'b1, 1'b0, "alarm_btn");
    run(15, 1'b1, 1'b0, 1'b0, "btn_latched");

    run(1,  1'b0, 1'b0, 1'b0, "clr_rst");
    run(10, 1'b1, 1'b0, 1'b0, "clr_idle");

    run(1,  1'b1, 1'b0, 1'b1, "smoke");
    run(55, 1'b1, 1'b0, 1'b0, "smoke_latched");

    run(1,  1'b0, 1'b0, 1'b1, "rst_smoke");
    run(12, 1'b1, 1'b0, 1'b1, "rearm_smoke");
    run(3,  1'b1, 1'b0, 1'b0, "rearm_hold");
    run(1,  1'b0, 1'b0, 1'b0, "rst_quiet");
    run(16, 1'b1, 1'b0, 1'b0, "quiet");

    // Trigger reaches the FSM on the same edge reset is low.
    run(1, 1'b1, 1'b1, 1'b0, "prio_btn");
    run(1, 1'b1, 1'b0, 1'b0, "prio_btn");
    run(1, 1'b0, 1'b0, 1'b0, "prio_rst");
    run(8, 1'b1, 1'b0, 1'b0, "prio_idle");

    run(1,  1'b1, 1'b1, 1'b1, "both");
    run(12, 1'b1, 1'b0, 1'b0, "both_latched");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
